// File: rtl/frame_buf_pp_if.sv
// =============================================================================
// frame_buf_pp_if : producer write port and consumer stream port of frame_buf_pp
// Revision 1.0
// =============================================================================
`default_nettype none

interface frame_buf_pp_if #(
    parameter int DATA_W = 8,
    parameter int AW     = 16
);
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_frame_done;
    logic              wr_frame_ack;
    logic              wr_frame_drop;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              rd_sof;
    logic              rd_eof;
    logic              rd_frame_done;
    logic [15:0]       drop_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, wr_frame_done, rd_ready,
        input  wr_frame_ack, wr_frame_drop, rd_data, rd_valid, rd_sof, rd_eof,
               rd_frame_done, drop_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_frame_done, rd_ready,
        output wr_frame_ack, wr_frame_drop, rd_data, rd_valid, rd_sof, rd_eof,
               rd_frame_done, drop_cnt
    );
endinterface

`default_nettype wire

// File: rtl/frame_buf_pp.sv
// =============================================================================
// frame_buf_pp : two-bank ping-pong frame buffer, addressed writes, raster stream
// out; define FRAME_BUF_DROP_CNT_EN to count dropped commits. Revision 1.0
// =============================================================================
`default_nettype none

module frame_buf_pp #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 240,
    parameter int IMG_H  = 176
) (
    input  wire logic     clk,
    input  wire logic     reset,
    frame_buf_pp_if.slave bus
);
    localparam int DEPTH = IMG_W * IMG_H;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_X   = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {FREE = 2'd0, FILLING = 2'd1, READY = 2'd2, BUSY = 2'd3} bank_t;
    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2} rd_state_t;

    logic [DATA_W-1:0] mem [2][DEPTH];
    bank_t             bank_st [2];
    logic              wr_bank;
    logic              other_bank;
    logic              rd_bank;
    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [AW-1:0]     rd_addr;

    logic [DATA_W-1:0] rd_q;
    logic              sof_q;
    logic              eof_q;
    logic              inflight;
    logic [DATA_W+1:0] fifo [2];
    logic [1:0]        fifo_cnt;
    logic              fifo_wp;
    logic              fifo_rp;

    logic              out_valid;
    logic [DATA_W+1:0] head;
    logic              pop;
    logic              fifo_pop;
    logic              push;
    logic [2:0]        occ_next;
    logic              issue;
    logic              start;
    logic              start_bank;
    logic              finish;
    logic              other_free;
    logic              commit_ok;
    logic              ack_q;
    logic              drop_q;
    logic              done_q;

    // Head is the FIFO front, or the freshly read word bypassing an empty FIFO.
    assign out_valid = (fifo_cnt != 2'd0) | inflight;
    assign head      = (fifo_cnt != 2'd0) ? fifo[fifo_rp] : {sof_q, eof_q, rd_q};
    assign pop       = out_valid & bus.rd_ready;
    assign fifo_pop  = pop & (fifo_cnt != 2'd0);
    assign push      = inflight & ~(pop & (fifo_cnt == 2'd0));
    assign occ_next  = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        start      = 1'b0;
        start_bank = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bank_st[0] == READY) begin
                    start     = 1'b1;
                    state_nxt = STREAM;
                end else if (bank_st[1] == READY) begin
                    start      = 1'b1;
                    start_bank = 1'b1;
                    state_nxt  = STREAM;
                end
            end
            STREAM: begin
                if (occ_next < 3'd2) begin
                    issue = 1'b1;
                    if (rd_addr == LAST_ADDR) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head[DATA_W]) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A bank released by the reader on this very edge counts as free.
    assign other_bank = ~wr_bank;
    assign other_free = (bank_st[other_bank] == FREE) || (finish && (rd_bank == other_bank));
    assign commit_ok  = bus.wr_frame_done & other_free;

    always_ff @(posedge clk) begin
        if (bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_X)) begin
            mem[wr_bank][bus.wr_addr] <= bus.wr_data;
        end
        if (issue) begin
            rd_q  <= mem[rd_bank][rd_addr];
            sof_q <= (rd_addr == '0);
            eof_q <= (rd_addr == LAST_ADDR);
        end
        if (push) fifo[fifo_wp] <= {sof_q, eof_q, rd_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rd_bank  <= 1'b0;
            rd_addr  <= '0;
            inflight <= 1'b0;
            fifo_cnt <= 2'd0;
            fifo_wp  <= 1'b0;
            fifo_rp  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            done_q   <= finish;
            if (start) begin
                rd_bank <= start_bank;
                rd_addr <= '0;
            end else if (issue) begin
                rd_addr <= rd_addr + AW'(1);
            end
            if (push)     fifo_wp <= ~fifo_wp;
            if (fifo_pop) fifo_rp <= ~fifo_rp;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, fifo_pop};
        end
    end

    // Commit is applied last so it overrides the reader's release of the same bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_st[0] <= FILLING;
            bank_st[1] <= FREE;
            wr_bank    <= 1'b0;
            ack_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            ack_q  <= commit_ok;
            drop_q <= bus.wr_frame_done & ~other_free;
            if (finish) bank_st[rd_bank] <= FREE;
            if (start)  bank_st[start_bank] <= BUSY;
            if (commit_ok) begin
                bank_st[wr_bank]    <= READY;
                bank_st[other_bank] <= FILLING;
                wr_bank             <= other_bank;
            end
        end
    end

`ifdef FRAME_BUF_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= 16'h0000;
        end else if (bus.wr_frame_done && !other_free && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`else
    assign bus.drop_cnt = 16'h0000;
`endif

    assign bus.rd_valid      = out_valid;
    assign bus.rd_data       = out_valid ? head[DATA_W-1:0] : '0;
    assign bus.rd_sof        = out_valid & head[DATA_W+1];
    assign bus.rd_eof        = out_valid & head[DATA_W];
    assign bus.rd_frame_done = done_q;
    assign bus.wr_frame_ack  = ack_q;
    assign bus.wr_frame_drop = drop_q;

endmodule

`default_nettype wire

// File: doc/frame_buf_pp.md
# frame_buf_pp

Parametrised ping-pong frame buffer between the pixel producer (UART RX / edge pipeline) and the frame consumer (UART TX / plotter path). It holds two frame banks of `DATA_W`-bit pixels. The producer writes one bank by address while the consumer streams the other out in raster order over a valid/ready interface. Frame hand-over is controlled by bank-state tracking with a defined drop policy.

## Interface
- `DATA_W`, 8, pixel width in bits
- `IMG_W`, 240, pixels per line
- `IMG_H`, 176, lines per frame; `DEPTH = IMG_W*IMG_H`, `AW = $clog2(DEPTH)`
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `wr_en`  in  1  write strobe
- `wr_addr`  in  AW  pixel address within the current write bank
- `wr_data`  in  DATA_W  pixel value
- `wr_frame_done`  in  1  one-cycle pulse; commits the current write bank
- `wr_frame_ack`  out  1  one-cycle pulse; commit accepted
- `wr_frame_drop`  out  1  one-cycle pulse; commit rejected, no free bank
- `rd_data`  out  DATA_W  streamed pixel
- `rd_valid`  out  1  `rd_data` valid
- `rd_ready`  in  1  consumer accepts the beat when `rd_valid & rd_ready`
- `rd_sof`  out  1  beat is pixel 0
- `rd_eof`  out  1  beat is pixel DEPTH-1
- `rd_frame_done`  out  1  one-cycle pulse after the last beat is accepted
- `drop_cnt`  out  16  dropped-frame count (see Configuration)

## Operation
- Each bank has a state: FREE, FILLING, READY or BUSY. `wr_bank` points at the FILLING bank.
- Write path:
  - `wr_en` writes `mem[wr_bank][wr_addr]` when `wr_addr < DEPTH`; out-of-range writes are ignored.
  - A write in the same cycle as `wr_frame_done` lands in the bank being committed.
- Commit:
  - Accepted if the other bank is FREE, or becomes FREE in the same cycle. The reader's finish has priority.
  - On accept: the current bank becomes READY, `wr_bank` toggles, the new bank becomes FILLING, and `wr_frame_ack` pulses.
  - On reject: the bank stays FILLING and is overwritten by the next frame, and `wr_frame_drop` pulses.
- Reader FSM states: IDLE, STREAM, DRAIN.
  - IDLE: if a bank is READY, mark it BUSY, set `rd_addr = 0` and go to STREAM.
  - STREAM: issue a synchronous read of `mem[rd_bank][rd_addr]` whenever `(fifo_cnt - pop) + inflight < 2`, then increment `rd_addr`. After issuing `DEPTH-1`, go to DRAIN.
  - DRAIN: on acceptance of the EOF beat, set the bank to FREE, pulse `rd_frame_done` and go to IDLE.
- Read data passes through a 2-entry output FIFO, giving full throughput with `rd_ready` held high.
- `rd_sof` and `rd_eof` travel with the data through the FIFO. `rd_data`, `rd_sof` and `rd_eof` are held stable while `rd_valid & ~rd_ready`.
- Reset, including mid-frame:
  - Both banks FREE, then bank 0 FILLING with `wr_bank = 0`.
  - Reader IDLE, FIFO flushed, in-flight read discarded.
  - Pulses low; `drop_cnt` cleared. Memory contents are not cleared.

## Timing
- Reset values: `rd_valid`, `rd_sof`, `rd_eof`, `rd_frame_done`, `wr_frame_ack`, `wr_frame_drop` all 0; `rd_data` 0; `drop_cnt` 0.
- Commit sampled at edge t:
  - `wr_frame_ack` or `wr_frame_drop` is high in cycle t+1.
  - The bank is READY in cycle t+1.
  - The reader enters STREAM at t+2 and issues address 0.
  - First `rd_valid` (with `rd_sof`) is at t+3.
- Memory read latency is 1 cycle; the FIFO adds 0 cycles on empty pass-through.
- With `rd_ready` held high, one beat per cycle: `DEPTH` beats in `DEPTH` consecutive cycles.
- `rd_frame_done` is high in the cycle after the EOF handshake. The bank is FREE in that same cycle, so a commit sampled then is accepted.
- A write to the bank being read is impossible by construction (FILLING is never BUSY).

## Configuration
- Macro: `FRAME_BUF_DROP_CNT_EN`.
- Defined: `drop_cnt` increments on each `wr_frame_drop`, saturates at 16'hFFFF, and is cleared only by reset.
- Undefined: `drop_cnt` is tied to 0 and no counter logic exists. The port is present in both builds.

## Test plan
- Reset, write frame A (pixel `i = i[7:0]`), commit, `rd_ready=1`:
  - `wr_frame_ack` at t+1, first beat at t+3 with `rd_sof`, `rd_data=0x00`.
  - 42240 contiguous beats, last with `rd_eof`, `rd_data=0xFF`, then `rd_frame_done`.
- Random `rd_ready` (50%) over a full frame:
  - No beat lost or duplicated; data stable during stalls.
  - `rd_sof` exactly once on beat 0, `rd_eof` exactly once on beat 42239.
- Commit frame A, hold `rd_ready=0`, write and commit frame B:
  - `wr_frame_drop` pulses; `drop_cnt=1` with the macro, 0 without.
  - A later frame C commit after A drains is acked and streamed with C data.
- Commit sampled on the same edge that accepts A's EOF beat: accepted (ack, not drop).
- Assert `reset` at beat 1000 of a stream:
  - Next cycle `rd_valid=0`, no `rd_frame_done`.
  - A subsequent full write and commit streams from `rd_sof` correctly.
- Write with `wr_addr=42240`: memory unchanged; the streamed frame matches the data written by the in-range writes only.
